// File: rtl/teller_dispatch.sv
// teller_dispatch: arbitrates "next customer" requests from up to three
// on-duty tellers, pulses the queue counter's decrement input once per grant,
// and holds the now-serving ticket and called-teller number for the displays.
module teller_dispatch #(
    parameter int HOLD_CYCLES = 4,
    parameter int TICKET_W    = 5
) (
    input  logic                clk,
    input  logic                reset,        // asynchronous, active-low
    input  logic [2:0]          ready,
    input  logic [2:0]          on_duty,
    input  logic                queue_empty,
    output logic                serve,
    output logic [1:0]          called_teller,
    output logic [TICKET_W-1:0] now_serving,
    output logic [2:0]          busy,
    output logic                call_valid
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARB      = 2'd1,
        SERVE    = 2'd2,
        ANNOUNCE = 2'd3
    } state_t;

    state_t              r_state;
    logic [2:0]          r_ready_q;
    logic [2:0]          r_pending;
    logic [2:0]          r_busy;
    logic [1:0]          r_grant;
    logic [1:0]          r_last_grant;
    logic [CNT_W-1:0]    r_hold_cnt;
    logic                r_serve;
    logic                r_call_valid;
    logic [1:0]          r_called_teller;
    logic [TICKET_W-1:0] r_now_serving;

    logic [2:0]          w_req_edge;
    logic [2:0]          w_grant_1h;
    logic [1:0]          w_pick;
    logic                w_any_pending;

    assign w_req_edge    = ready & ~r_ready_q;
    assign w_any_pending = |r_pending;
    // The grant takes effect on the edge that leaves SERVE.
    assign w_grant_1h    = (r_state == SERVE) ? (3'b001 << r_grant) : 3'b000;

    // Round-robin pick: search starts at the teller after the last grant.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_pick = 2'd0;
        case (r_last_grant)
            2'd0: begin
                if (r_pending[1])      w_pick = 2'd1;
                else if (r_pending[2]) w_pick = 2'd2;
                else                   w_pick = 2'd0;
            end
            2'd1: begin
                if (r_pending[2])      w_pick = 2'd2;
                else if (r_pending[0]) w_pick = 2'd0;
                else                   w_pick = 2'd1;
            end
            default: begin
                if (r_pending[0])      w_pick = 2'd0;
                else if (r_pending[1]) w_pick = 2'd1;
                else                   w_pick = 2'd2;
            end
        endcase
    end

    // Request edge detection plus pending and busy bookkeeping per teller.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ready_q <= 3'b000;
            r_pending <= 3'b000;
            r_busy    <= 3'b000;
        end else begin
            r_ready_q <= ready;
            // Going off duty or being granted wipes the request; that clear
            // beats a request edge arriving on the same cycle.
            r_pending <= (r_pending | (w_req_edge & on_duty)) & ~w_grant_1h & on_duty;
            // A fresh request edge means the teller finished the last customer.
            r_busy    <= ((r_busy & ~w_req_edge) | w_grant_1h) & on_duty;
        end
    end

    // Dispatch FSM with registered serve/announce/display outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_grant         <= 2'd0;
            r_last_grant    <= 2'd2;
            r_hold_cnt      <= '0;
            r_serve         <= 1'b0;
            r_call_valid    <= 1'b0;
            r_called_teller <= 2'd0;
            r_now_serving   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_pending && !queue_empty) begin
                        r_state <= ARB;
                    end
                end
                ARB: begin
                    // Conditions are re-checked here; the queue may have
                    // drained or the requester left since IDLE looked.
                    if (queue_empty || !w_any_pending) begin
                        r_state <= IDLE;
                    end else begin
                        r_grant <= w_pick;
                        r_serve <= 1'b1;
                        r_state <= SERVE;
                    end
                end
                SERVE: begin
                    r_serve         <= 1'b0;
                    r_now_serving   <= r_now_serving + 1'b1;
                    r_called_teller <= r_grant + 2'd1;
                    r_last_grant    <= r_grant;
                    r_call_valid    <= 1'b1;
                    r_hold_cnt      <= HOLD_LOAD;
                    r_state         <= ANNOUNCE;
                end
                ANNOUNCE: begin
                    if (r_hold_cnt == '0) begin
                        r_call_valid <= 1'b0;
                        r_state      <= IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign serve         = r_serve;
    assign call_valid    = r_call_valid;
    assign called_teller = r_called_teller;
    assign now_serving   = r_now_serving;
    assign busy          = r_busy;

endmodule
